bsg_one_hot_encoder_reg: RTL and testbench
==========================================

// Module: bsg_one_hot_encoder_reg
// PURPOSE
//   Registered one-hot to binary encoder. Converts a width_p-bit one-hot vector into
//   a binary index plus a valid flag, with the result registered.
//   Sits behind arbiters and grant vectors that need a compact index.
//   Defined priority for illegal multi-hot inputs; optional debug checking.
// PARAMETERS
//   width_p     31  input vector width, >=1
//   lo_to_hi_p  1   1: the lowest set bit wins on multi-hot; 0: the highest set bit wins
//   debug_p     0   1: simulation-only $error when registered input is multi-hot
//   addr_w_lp   derived = `BSG_SAFE_CLOG2(width_p) (1 when width_p==1)
// PORTS
//   clk_i     in   1          clock, rising edge
//   reset_i   in   1          asynchronous reset, active-high
//   i         in   width_p    one-hot (or zero) input vector
//   addr_o    out  addr_w_lp  binary index of the set bit, registered
//   v_o       out  1          1 when any bit of i was set, registered
//   multi_o   out  1          only with ONE_HOT_MULTI_DETECT_EN: >1 bit was set
// BEHAVIOUR
//   - Reset: addr_o=0, v_o=0 (and multi_o=0) immediately on reset_i rise, async.
//     Hold these values while reset_i=1.
//   - Latency: 1 cycle. Outputs at edge N+1 reflect i sampled at edge N.
//     No handshake; a new input is accepted every cycle.
//   - Encoding is computed combinationally, then registered:
//       v_next = |i
//       i == 0              -> addr_next = 0, v_next = 0
//       exactly bit k set   -> addr_next = k
//       multi-hot           -> addr_next = index of the winning bit per lo_to_hi_p (never an OR of indices)
//   - addr_o zero-extends k into addr_w_lp bits. Indices >= width_p cannot occur.
//   - Non-power-of-2 width_p (e.g. 31): internally pad to 2**addr_w_lp bits with zeros.
//     Padding must not affect v_o or addr_o.
//   - width_p==1: addr_o is constant 0 and v_o = registered i[0].
//   - Reset deasserted mid-stream: the first capture is at the first rising edge with reset_i=0.
//   - debug_p=1: at each clock edge with reset_i=0 and $countones(i)>1, issue $error
//     with the vector value. Behaviour is otherwise unchanged. Excluded from synthesis.
// CONFIGURATION
//   ONE_HOT_MULTI_DETECT_EN defined: adds output multi_o.
//     multi_o is registered, 1-cycle latency, reset 0.
//     multi_o = 1 when more than one bit of i was set.
//   ONE_HOT_MULTI_DETECT_EN undefined: the multi_o port and its logic are absent.
//     All other behaviour is identical.
// STRUCTURE
//   - Package bsg_one_hot_encoder_pkg holds:
//       function addr_width(width) (safe clog2)
//       localparam for the padded width
//   - Sub-module bsg_one_hot_encode_tree: combinational, parameterised by width and lo_to_hi.
//     Recursive halving tree: each level produces (v, addr).
//     The winning half is selected per priority; the half-select bit is prepended as the
//     address MSB.
//   - Top level:
//       instantiates the tree
//       one async-reset register bank for addr_o / v_o / multi_o
//       debug check under `ifndef SYNTHESIS
// TESTING (width_p=31, lo_to_hi_p=1, debug_p=1 unless noted)
//   1. Hold reset_i=1, drive i=31'h4 -> addr_o=0, v_o=0.
//      Assert reset_i asynchronously mid-cycle -> outputs clear without waiting for a clock.
//   2. i=0 -> one cycle later v_o=0, addr_o=0.
//   3. Walk i=1<<k for k=0..30 every cycle:
//      each result appears 1 cycle later with addr_o=k, v_o=1 (k=30 -> addr_o=5'd30).
//   4. Drive i=1<<31, which truncates to 0 -> v_o=0, addr_o=0.
//      No debug $error.
//   5. Drive i=31'h0000_0A00 (bits 9 and 11 set):
//      lo_to_hi_p=1 -> addr_o=9; lo_to_hi_p=0 -> addr_o=11.
//      v_o=1, one $error per cycle; with ONE_HOT_MULTI_DETECT_EN, multi_o=1.
//   6. width_p=1: i toggles 1,0 -> v_o follows 1 cycle later and addr_o stays 0.
//      Also check width_p=32 with i=1<<31 -> addr_o=31.

Source files
------------

// File: rtl/bsg_one_hot_encoder_pkg.sv
// Shared sizing helpers for the registered one-hot encoder and its encode tree.
// Optional multi-hot flag output is enabled by defining ONE_HOT_MULTI_DETECT_EN.
package bsg_one_hot_encoder_pkg;

  // Safe clog2: a single-bit vector still needs a one-bit address.
  function automatic int addr_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

  function automatic int padded_width(input int width);
    return 1 << addr_width(width);
  endfunction

  localparam int default_width_lp        = 31;
  localparam int default_padded_width_lp = padded_width(default_width_lp);

endpackage

// File: rtl/bsg_one_hot_encode_tree.sv
// Combinational recursive halving tree: one-hot (or zero) vector to (valid, index).
// width_p must be a power of two; the caller zero-pads. addr_o is 0 whenever v_o is 0.
module bsg_one_hot_encode_tree
  import bsg_one_hot_encoder_pkg::*;
#(
  parameter int width_p    = default_padded_width_lp,
  parameter int lo_to_hi_p = 1,
  localparam int addr_w_lp = addr_width(width_p)
) (
  input  logic [width_p-1:0]   i,
  output logic                 v_o,
  output logic [addr_w_lp-1:0] addr_o
);

  if (width_p == 1) begin : g_leaf1
    assign v_o    = i[0];
    assign addr_o = '0;
  end else if (width_p == 2) begin : g_leaf2
    assign v_o = |i;
    if (lo_to_hi_p != 0) begin : g_lo
      assign addr_o = i[1] & ~i[0];
    end else begin : g_hi
      assign addr_o = i[1];
    end
  end else begin : g_node
    localparam int half_lp  = width_p / 2;
    localparam int sub_w_lp = addr_w_lp - 1;

    logic                lo_v;
    logic                hi_v;
    logic [sub_w_lp-1:0] lo_addr;
    logic [sub_w_lp-1:0] hi_addr;

    bsg_one_hot_encode_tree #(
      .width_p   (half_lp),
      .lo_to_hi_p(lo_to_hi_p)
    ) lo_tree (
      .i     (i[half_lp-1:0]),
      .v_o   (lo_v),
      .addr_o(lo_addr)
    );

    bsg_one_hot_encode_tree #(
      .width_p   (half_lp),
      .lo_to_hi_p(lo_to_hi_p)
    ) hi_tree (
      .i     (i[width_p-1:half_lp]),
      .v_o   (hi_v),
      .addr_o(hi_addr)
    );

    assign v_o = lo_v | hi_v;

    // Half-select bit becomes the MSB; an empty half reports address 0 so idle stays 0.
    if (lo_to_hi_p != 0) begin : g_lo
      assign addr_o = lo_v ? {1'b0, lo_addr} : {hi_v, hi_addr};
    end else begin : g_hi
      assign addr_o = hi_v ? {1'b1, hi_addr} : {1'b0, lo_addr};
    end
  end

endmodule

// File: rtl/bsg_one_hot_encoder_reg.sv
// Registered one-hot to binary encoder (1-cycle latency, async active-high reset).
// Define ONE_HOT_MULTI_DETECT_EN to add the registered multi_o multi-hot flag.
module bsg_one_hot_encoder_reg
  import bsg_one_hot_encoder_pkg::*;
#(
  parameter int width_p    = default_width_lp,
  parameter int lo_to_hi_p = 1,
  parameter int debug_p    = 0,
  localparam int addr_w_lp = addr_width(width_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [width_p-1:0]   i,
  output logic [addr_w_lp-1:0] addr_o,
  output logic                 v_o
`ifdef ONE_HOT_MULTI_DETECT_EN
  ,
  output logic                 multi_o
`endif
);

  localparam int padded_w_lp = padded_width(width_p);

  logic [padded_w_lp-1:0] padded;
  logic [addr_w_lp-1:0]   addr_next;
  logic                   v_next;

  assign padded[width_p-1:0] = i;
  if (padded_w_lp > width_p) begin : g_pad
    assign padded[padded_w_lp-1:width_p] = '0;
  end

  bsg_one_hot_encode_tree #(
    .width_p   (padded_w_lp),
    .lo_to_hi_p(lo_to_hi_p)
  ) tree (
    .i     (padded),
    .v_o   (v_next),
    .addr_o(addr_next)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_o <= '0;
      v_o    <= 1'b0;
    end else begin
      addr_o <= addr_next;
      v_o    <= v_next;
    end
  end

`ifdef ONE_HOT_MULTI_DETECT_EN
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  logic multi_next;
  assign multi_next = (i & (i - width_p'(1))) != '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      multi_o <= 1'b0;
    end else begin
      multi_o <= multi_next;
    end
  end
`endif

`ifndef SYNTHESIS
  if (debug_p != 0) begin : g_debug
    always @(posedge clk_i) begin
      if (!reset_i && ($countones(i) > 1)) begin
        $error("bsg_one_hot_encoder_reg: multi-hot input %b", i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_one_hot_encoder_reg.sv
// Scoreboard bench: drives one 32-bit stimulus into width-31 (both priorities), width-1 and
// width-32 encoders; a monitor pops model-computed expectations one cycle after capture.
module tb_bsg_one_hot_encoder_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [31:0] stim;

  logic [4:0] addr_lo, addr_hi, addr_w32;
  logic [0:0] addr_w1;
  logic       v_lo, v_hi, v_w1, v_w32;
`ifdef ONE_HOT_MULTI_DETECT_EN
  logic multi_lo, multi_hi, multi_w1, multi_w32;
`endif

  bsg_one_hot_encoder_reg #(.width_p(31), .lo_to_hi_p(1), .debug_p(0)) dut_lo (
    .clk_i(clk), .reset_i(reset_i), .i(stim[30:0]), .addr_o(addr_lo), .v_o(v_lo)
`ifdef ONE_HOT_MULTI_DETECT_EN
    , .multi_o(multi_lo)
`endif
  );

  bsg_one_hot_encoder_reg #(.width_p(31), .lo_to_hi_p(0), .debug_p(0)) dut_hi (
    .clk_i(clk), .reset_i(reset_i), .i(stim[30:0]), .addr_o(addr_hi), .v_o(v_hi)
`ifdef ONE_HOT_MULTI_DETECT_EN
    , .multi_o(multi_hi)
`endif
  );

  bsg_one_hot_encoder_reg #(.width_p(1), .lo_to_hi_p(1), .debug_p(0)) dut_w1 (
    .clk_i(clk), .reset_i(reset_i), .i(stim[0:0]), .addr_o(addr_w1), .v_o(v_w1)
`ifdef ONE_HOT_MULTI_DETECT_EN
    , .multi_o(multi_w1)
`endif
  );

  bsg_one_hot_encoder_reg #(.width_p(32), .lo_to_hi_p(1), .debug_p(0)) dut_w32 (
    .clk_i(clk), .reset_i(reset_i), .i(stim), .addr_o(addr_w32), .v_o(v_w32)
`ifdef ONE_HOT_MULTI_DETECT_EN
    , .multi_o(multi_w32)
`endif
  );

  typedef struct {
    logic [31:0] vec;
    int          a_lo;
    int          a_hi;
    logic        v31;
    logic        multi31;
    logic        v1;
    int          a32;
    logic        v32;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan the bits directly; nothing set means index 0.
  function automatic int lowest_set(input logic [31:0] v, input int w);
    for (int k = 0; k < w; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic int highest_set(input logic [31:0] v, input int w);
    for (int k = w - 1; k >= 0; k--) if (v[k]) return k;
    return 0;
  endfunction

  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    logic [31:0] v31;
    v31       = v & 32'h7FFF_FFFF;
    e.vec     = v;
    e.a_lo    = lowest_set(v31, 31);
    e.a_hi    = highest_set(v31, 31);
    e.v31     = (v31 != 0);
    e.multi31 = ($countones(v31) > 1);
    e.v1      = v[0];
    e.a32     = lowest_set(v, 32);
    e.v32     = (v != 0);
    return e;
  endfunction

  task automatic drive(input logic [31:0] v);
    @(negedge clk);
    stim = v;
    sb.push_back(model(v));
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_addr_lo"}, 32'(addr_lo), 0);
    check({tag, "_v_lo"},    32'(v_lo),    0);
    check({tag, "_addr_hi"}, 32'(addr_hi), 0);
    check({tag, "_v_hi"},    32'(v_hi),    0);
    check({tag, "_v_w1"},    32'(v_w1),    0);
    check({tag, "_addr_w32"},32'(addr_w32),0);
    check({tag, "_v_w32"},   32'(v_w32),   0);
`ifdef ONE_HOT_MULTI_DETECT_EN
    check({tag, "_multi_lo"},32'(multi_lo),0);
`endif
  endtask

  // Monitor: each rising edge with a queued expectation presents a result 2ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn stim=%h lo=%0d/%b hi=%0d/%b w1=%0d/%b w32=%0d/%b",
                 e.vec, addr_lo, v_lo, addr_hi, v_hi, addr_w1, v_w1, addr_w32, v_w32);
        check("addr_lo",  32'(addr_lo),  32'(e.a_lo));
        check("v_lo",     32'(v_lo),     32'(e.v31));
        check("addr_hi",  32'(addr_hi),  32'(e.a_hi));
        check("v_hi",     32'(v_hi),     32'(e.v31));
        check("addr_w1",  32'(addr_w1),  0);
        check("v_w1",     32'(v_w1),     32'(e.v1));
        check("addr_w32", 32'(addr_w32), 32'(e.a32));
        check("v_w32",    32'(v_w32),    32'(e.v32));
`ifdef ONE_HOT_MULTI_DETECT_EN
        check("multi_lo", 32'(multi_lo), 32'(e.multi31));
        check("multi_hi", 32'(multi_hi), 32'(e.multi31));
`endif
      end
    end
  end

  task automatic drain(input string tag);
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    @(posedge clk);
    #3;
    check({tag, "_drain"}, 32'(sb.size()), 0);
  endtask

  initial begin
    logic [31:0] r;
    reset_i = 1'b1;
    stim    = 32'h4;
    repeat (3) @(negedge clk);
    check_all_clear("reset_hold");

    // First capture must be the first rising edge after release.
    @(negedge clk);
    reset_i = 1'b0;
    stim    = 32'h0;
    sb.push_back(model(32'h0));

    for (int k = 0; k < 32; k++) drive(32'h1 << k);
    drive(32'h0000_0A00);
    drive(32'h4000_0001);
    drive(32'h7FFF_FFFF);
    drive(32'hFFFF_FFFF);
    drive(32'h8000_0000);
    drive(32'h1);
    drive(32'h0);
    drive(32'h1);
    drive(32'h0);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       r = 32'h0;
        1:       r = 32'h1 << $urandom_range(0, 31);
        2:       r = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        default: r = $urandom;
      endcase
      drive(r);
    end
    drain("main");

    // Asynchronous reset mid-cycle with a live result on the outputs.
    drive(32'h0000_0410);
    @(posedge clk);
    #3;
    reset_i = 1'b1;
    #1;
    check_all_clear("async_rst");
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      stim = $urandom | 32'h1;
      @(posedge clk);
      #2;
      check_all_clear("rst_held");
    end

    @(negedge clk);
    reset_i = 1'b0;
    stim    = 32'h0000_0100;
    sb.push_back(model(32'h0000_0100));
    for (int n = 0; n < 20; n++) drive($urandom);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
